// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: operand/register-id types, reset constants and reset-value helper for regfile_mp.
package regfile_mp_pkg;
  typedef logic [31:0] op_t;
  typedef logic [4:0]  reg_id_t;
  localparam op_t GPAt   = 32'h1000_8000;
  localparam op_t SPAt   = 32'h7fff_fff0;
  localparam int  GP_REG = 28;
  localparam int  SP_REG = 29;
  function automatic op_t reset_val(input int i);
    return i == GP_REG ? GPAt : i == SP_REG ? SPAt : '0;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and claim bundle between decode/writeback (master) and regfile_mp (slave).
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int IW = $clog2(NREGS);
  logic [IW-1:0]     rd_id   [NREAD];
  op_t               rd_data [NREAD];
  logic [NREAD-1:0]  rd_busy;
  logic [NWRITE-1:0] wr_en;
  logic [IW-1:0]     wr_id   [NWRITE];
  op_t               wr_data [NWRITE];
  logic              claim_en;
  logic [IW-1:0]     claim_id;
  logic              claim_full;
  modport master (
    output rd_id, wr_en, wr_id, wr_data, claim_en, claim_id,
    input  rd_data, rd_busy, claim_full
  );
  modport slave (
    input  rd_id, wr_en, wr_id, wr_data, claim_en, claim_id,
    output rd_data, rd_busy, claim_full
  );
endinterface

// File: rtl/regfile_pend_ctr.sv
// regfile_pend_ctr: per-register pending-producer counter, saturating up / clamped down.
// REGFILE_BYPASS_EN makes o_busy reflect the next count instead of the stored one.
module regfile_pend_ctr #(
  parameter int PEND_W = 2,
  parameter int DW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_claim,
  input  logic [DW-1:0] i_dec,
  output logic          o_busy,
  output logic          o_full
);
  localparam int SW = PEND_W + DW + 1;
  logic [PEND_W-1:0] r_cnt;
  logic [PEND_W-1:0] w_nxt;
  logic [SW-1:0]     w_up;
  assign o_full = &r_cnt;
  // a claim is dropped while saturated; writebacks beyond the count clamp at zero
  assign w_up   = SW'(r_cnt) + SW'(i_claim && !o_full);
  assign w_nxt  = SW'(i_dec) >= w_up ? '0 : PEND_W'(w_up - SW'(i_dec));
`ifdef REGFILE_BYPASS_EN
  assign o_busy = w_nxt != '0;
`else
  assign o_busy = r_cnt != '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_nxt;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero and per-register pending-write scoreboard.
// REGFILE_BYPASS_EN forwards same-cycle writeback data and next-state busy to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int PEND_W = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave rf
);
  localparam int IW = $clog2(NREGS);
  localparam int DW = $clog2(NWRITE + 1);
  op_t              r_regs [NREGS];
  logic [DW-1:0]    w_dec  [1:NREGS-1];
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_full;
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < NWRITE; p++)
        w_dec[r] = w_dec[r] + DW'(rf.wr_en[p] && rf.wr_id[p] == IW'(r));
    end
  end
  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;
  for (genvar g = 1; g < NREGS; g++) begin : g_ctr
    regfile_pend_ctr #(.PEND_W(PEND_W), .DW(DW)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_claim (rf.claim_en && rf.claim_id == IW'(g)),
      .i_dec   (w_dec[g]),
      .o_busy  (w_busy[g]),
      .o_full  (w_full[g])
    );
  end
  assign rf.claim_full = w_full[rf.claim_id];
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      rf.rd_data[k] = r_regs[rf.rd_id[k]];
      rf.rd_busy[k] = w_busy[rf.rd_id[k]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWRITE; p++)
        if (rf.wr_en[p] && rf.wr_id[p] == rf.rd_id[k] && rf.rd_id[k] != '0)
          rf.rd_data[k] = rf.wr_data[p];
`endif
    end
  end
  // later ports are assigned last so the youngest writeback wins on a shared id
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= reset_val(i);
    end else begin
      for (int p = 0; p < NWRITE; p++)
        if (rf.wr_en[p] && rf.wr_id[p] != '0) r_regs[rf.wr_id[p]] <= rf.wr_data[p];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp reads, write priority, x0, scoreboard and reset.
module tb_regfile_mp;
  import regfile_mp_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_mp_if #(.NREGS(32), .NREAD(2), .NWRITE(2)) rf();
  regfile_mp #(.NREGS(32), .NREAD(2), .NWRITE(2), .PEND_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rf.wr_en      = '0;
    rf.wr_id[0]   = '0;
    rf.wr_id[1]   = '0;
    rf.wr_data[0] = '0;
    rf.wr_data[1] = '0;
    rf.claim_en   = 1'b0;
    rf.claim_id   = '0;
  endtask
  task automatic wr(input int p, input logic [4:0] id, input op_t d);
    rf.wr_en[p]   = 1'b1;
    rf.wr_id[p]   = id;
    rf.wr_data[p] = d;
  endtask
  task automatic claim(input logic [4:0] id);
    rf.claim_en = 1'b1;
    rf.claim_id = id;
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rf.rd_id[0] = a;
    rf.rd_id[1] = b;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    rf.rd_id[0] = '0;
    rf.rd_id[1] = '0;
    wr(0, 5'd9, 32'hBAD);
    claim(5'd9);
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    rd(28, 29);
    chk("rst_gp", rf.rd_data[0], GPAt);
    chk("rst_sp", rf.rd_data[1], SPAt);
    chk("rst_busy", rf.rd_busy, 0);
    rd(5, 9);
    chk("rst_r5", rf.rd_data[0], 0);
    chk("rst_r9", rf.rd_data[1], 0);
    chk("rst_busy9", rf.rd_busy, 0);
    rf.claim_id = 5'd9;
    #1;
    chk("rst_cfull", rf.claim_full, 0);
    idle();
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(7, 7);
    chk("r7_same", rf.rd_data[0], BYP ? 32'h22 : 32'h0);
    tick();
    idle();
    rd(7, 7);
    chk("r7_next", rf.rd_data[0], 32'h22);
    wr(1, 5'd8, 32'h55);
    wr(0, 5'd8, 32'h66);
    tick();
    idle();
    rd(8, 7);
    chk("r8_prio", rf.rd_data[0], 32'h55);
    chk("r7_keep", rf.rd_data[1], 32'h22);
    wr(0, 5'd0, 32'hDEAD);
    claim(5'd0);
    rd(0, 0);
    chk("x0_same", rf.rd_data[0], 0);
    chk("x0_cfull", rf.claim_full, 0);
    tick();
    idle();
    rd(0, 0);
    chk("x0_next", rf.rd_data[1], 0);
    chk("x0_busy", rf.rd_busy, 0);
    for (int i = 0; i < 3; i++) begin
      claim(5'd3);
      rd(3, 3);
      chk($sformatf("r3_cfull_%0d", i), rf.claim_full, 0);
      tick();
    end
    rd(3, 3);
    chk("r3_cfull_sat", rf.claim_full, 1);
    chk("r3_busy_sat", rf.rd_busy[0], 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      wr(0, 5'd3, 32'h30 + i);
      rd(3, 3);
      chk($sformatf("r3_wb_same_%0d", i), rf.rd_busy[0], BYP ? (i < 2) : 1'b1);
      tick();
      idle();
      rf.claim_id = 5'd3;
      rd(3, 3);
      chk($sformatf("r3_wb_next_%0d", i), rf.rd_busy[0], i < 2);
      chk($sformatf("r3_wb_cfull_%0d", i), rf.claim_full, 0);
    end
    chk("r3_data", rf.rd_data[1], 32'h32);
    idle();
    claim(5'd4);
    tick();
    idle();
    rd(4, 4);
    chk("r4_busy1", rf.rd_busy[0], 1);
    claim(5'd4);
    wr(0, 5'd4, 32'h44);
    rd(4, 4);
    chk("r4_cw_busy_same", rf.rd_busy[0], 1);
    chk("r4_cw_data_same", rf.rd_data[0], BYP ? 32'h44 : 32'h0);
    tick();
    idle();
    rd(4, 4);
    chk("r4_cw_busy", rf.rd_busy[0], 1);
    chk("r4_cw_data", rf.rd_data[0], 32'h44);
    wr(1, 5'd4, 32'h45);
    tick();
    idle();
    rd(4, 4);
    chk("r4_done_busy", rf.rd_busy[0], 0);
    chk("r4_done_data", rf.rd_data[0], 32'h45);
    claim(5'd3);
    tick();
    tick();
    idle();
    rd(3, 3);
    chk("r3_pend2", rf.rd_busy[0], 1);
    rst_n = 1'b0;
    wr(0, 5'd3, 32'h99);
    wr(1, 5'd7, 32'h77);
    claim(5'd3);
    tick();
    rst_n = 1'b1;
    idle();
    rd(3, 7);
    chk("mrst_r3", rf.rd_data[0], 0);
    chk("mrst_r7", rf.rd_data[1], 0);
    chk("mrst_busy", rf.rd_busy, 0);
    rd(28, 29);
    chk("mrst_gp", rf.rd_data[0], GPAt);
    chk("mrst_sp", rf.rd_data[1], SPAt);
    wr(0, 5'd3, 32'h55);
    wr(1, 5'd3, 32'h56);
    rd(3, 3);
    chk("clamp_busy_same", rf.rd_busy[0], 0);
    tick();
    idle();
    rd(3, 3);
    chk("clamp_busy", rf.rd_busy[0], 0);
    chk("clamp_data", rf.rd_data[0], 32'h56);
    chk("clamp_cfull", rf.claim_full, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with per-register pending-write scoreboard, the successor to the single-write, two-read register file in the decode/writeback path. Serves NREAD asynchronous read ports and NWRITE synchronous write ports, holds x0 at zero, and initialises GP/SP on reset. Tracks outstanding producers per register so decode can detect RAW/WAW hazards without a separate scoreboard block.

## Interface
- NREGS, 32: number of architectural registers (power of two; index width = $clog2(NREGS), matches reg_id_t when 32)
- NREAD, 2: read ports
- NWRITE, 2: write ports; higher index = younger writeback
- PEND_W, 2: pending-counter width per register; max outstanding producers = 2^PEND_W-1
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- rd_id[NREAD]  in  reg_id_t  read addresses
- rd_data[NREAD]  out  op_t  read data (combinational)
- rd_busy[NREAD]  out  1  register has ≥1 pending producer
- wr_en[NWRITE]  in  1  write strobe
- wr_id[NWRITE]  in  reg_id_t  write address
- wr_data[NWRITE]  in  op_t  write data
- claim_en  in  1  issue stage reserves destination
- claim_id  in  reg_id_t  destination being reserved
- claim_full  out  1  claim_id counter at max; claim will be dropped

## Operation
- Reset (rst_n=0 at posedge): all regs 0 except reg GP_REG=GPAt, SP_REG=SPAt; all pending counters 0. During reset, wr_en/claim_en ignored.
- x0: reads always 0, rd_busy=0; writes and claims to x0 ignored; claim_full=0 for x0.
- Writes: each enabled port with wr_id≠0 updates its register at posedge. Same wr_id on multiple ports: highest port index's data wins.
- Pending counter per register, next = cur + inc − dec, where inc = claim_en && claim_id==r && !claim_full, dec = count of enabled write ports targeting r; clamped at 0 (no underflow; write to non-pending reg still updates data).
- Claim and write to the same reg in one cycle: net counter change = 1 − dec (claim plus one write → unchanged).
- claim_full = claim_id≠0 && counter[claim_id]==2^PEND_W−1, combinational; dropped claim leaves counter unchanged. Decode must stall on claim_full.
- rd_busy = counter[rd_id]≠0 (see bypass below).

## Timing
- Reads: zero-cycle combinational from rd_id and stored state.
- Writes/claims: visible on read ports the cycle after the posedge that captures them.
- Reset values: rd_data reflects reset contents (0 / GPAt / SPAt), rd_busy=0, claim_full=0 once reset has been applied.
- Reset mid-operation: pending counts discarded; stalled claims not replayed.

## Configuration
- REGFILE_BYPASS_EN defined: read of register r with any enabled write to r this cycle returns the winning (highest-index) wr_data; rd_busy computed from next counter (cur+inc−dec), so a final writeback shows busy=0 same cycle. x0 never bypassed.
- Undefined: rd_data and rd_busy come from stored state only; same-cycle writes seen next cycle.

## Structure
- Types package: op_t, reg_id_t (existing).
- Parameters package: GPAt, SPAt (existing); add GP_REG=28, SP_REG=29.
- One sub-module: regfile_pend_ctr (one PEND_W-bit saturating up/down counter with clamp and full flag), instantiated NREGS−1 times; data array and write-priority logic live in regfile_mp.

## Test plan
- Reset then read 28, 29, 5 -> GPAt, SPAt, 0; all rd_busy=0.
- Write port0 and port1 both to r7 (0x11, 0x22) -> r7 reads 0x22 next cycle; with bypass, 0x22 in same cycle.
- Write 0xDEAD to x0 and claim x0 -> x0 reads 0, rd_busy=0, claim_full=0.
- Claim r3 three times (PEND_W=2) -> claim_full=1 on 4th attempt, counter stays 3; three writebacks -> rd_busy falls after third (same cycle with bypass, next cycle without).
- Same cycle claim r4 + write r4 while count=1 -> count stays 1, rd_busy=1, data updated.
- Assert rst_n=0 with r3 pending=2 and writes active -> next cycle counters 0, r3=0, writes in reset cycle dropped.
